logo_frame_streamer: RTL and testbench

- Raster-scan sequencer and video-stream source for the 2-bit logo pixel memory.
- Drives column/row coordinates to the memory's combinational lookup and maps the returned 2-bit code through a 4-entry palette.
- Emits a registered 24-bit RGB pixel stream with valid/ready backpressure and start-of-frame/end-of-line markers to the downstream frame output stage.

---
 rtl/logo_frame_streamer.sv | 172 +++++++++++++++++
 tb/tb_logo_frame_streamer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logo_frame_streamer.sv
// Raster-scan sequencer and RGB stream source for the 2-bit logo pixel memory.
// Walks (pix_x, pix_y) over the frame, maps each returned code through a
// 4-entry palette and emits a registered valid/ready pixel stream with
// start-of-frame and end-of-line markers.
// Optional feature: define LOGO_FRAME_COUNT_EN to add the 16-bit frame_count output.
module logo_frame_streamer #(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter logic [23:0] COLOR0       = 24'h000000,
  parameter logic [23:0] COLOR1       = 24'hFFFFFF,
  parameter logic [23:0] COLOR2       = 24'hFF0000,
  parameter logic [23:0] COLOR3       = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] pix_x,
  output logic [31:0] pix_y,
  input  logic [1:0]  pix_value,
  output logic [23:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic        m_eol,
  output logic        busy,
  output logic        frame_done
`ifdef LOGO_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  // Degenerate one-pixel dimensions still get a 1-bit counter.
  localparam int unsigned XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] XMax = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] YMax = YW'(FRAME_HEIGHT - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [23:0]   r_data;
  logic          r_valid;
  logic          r_sof;
  logic          r_eol;
  logic          r_last;
  logic          r_frame_done;
  logic          w_load;
  logic          w_busy;
  logic          w_x_last;
  logic          w_y_last;
  logic [23:0]   w_color;

  assign w_x_last = (r_x == XMax);
  assign w_y_last = (r_y == YMax);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave ACTIVE only once the final pixel of a frame is loaded.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (enable) begin
          w_state_next = StActive;
        end
      end
      StActive: begin
        if (w_load && w_x_last && w_y_last && !enable) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: load a new pixel whenever the output slot is free or draining.
  always_comb begin
    w_busy = (r_state == StActive);
    w_load = w_busy && (!r_valid || m_ready);
  end

  // Palette lookup of the code for the currently presented coordinate.
  always_comb begin
    w_color = COLOR0;
    unique case (pix_value)
      2'b00: w_color = COLOR0;
      2'b01: w_color = COLOR1;
      2'b10: w_color = COLOR2;
      2'b11: w_color = COLOR3;
      default: w_color = COLOR0;
    endcase
  end

  // Raster counters advance once per loaded pixel and hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_load) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Output register: load on a free slot, hold on stall, drop valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_color;
      r_valid <= 1'b1;
      r_sof   <= (r_x == '0) && (r_y == '0);
      r_eol   <= w_x_last;
      r_last  <= w_x_last && w_y_last;
    end else if (m_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Frame-done pulse follows acceptance of the frame's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_valid && m_ready && r_last;
    end
  end

`ifdef LOGO_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Frame counter steps on the same edge that raises frame_done; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= '0;
    end else if (r_valid && m_ready && r_last) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

  assign pix_x      = 32'(r_x);
  assign pix_y      = 32'(r_y);
  assign m_data     = r_data;
  assign m_valid    = r_valid;
  assign m_sof      = r_sof;
  assign m_eol      = r_eol;
  assign busy       = w_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_logo_frame_streamer.sv
// Randomized self-checking bench for logo_frame_streamer on a 4x3 frame.
// The reference model numbers accepted beats and derives each beat's
// coordinate, colour and markers arithmetically from that running index.
module tb_logo_frame_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] pix_x;
  logic [31:0] pix_y;
  logic [1:0]  pix_value;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sof;
  logic        m_eol;
  logic        busy;
  logic        frame_done;
`ifdef LOGO_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  logo_frame_streamer #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .COLOR0      (24'd1),
    .COLOR1      (24'd2),
    .COLOR2      (24'd3),
    .COLOR3      (24'd4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_value  (pix_value),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef LOGO_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  // Logo memory stand-in: code = (x + y) mod 4.
  assign pix_value = 2'((pix_x + pix_y) % 4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, owned by the monitor.
  int          beats    = 0;
  int          frames   = 0;
  bit          acc_last = 1'b0;
  bit          held     = 1'b0;
  logic [23:0] h_data;
  logic        h_sof;
  logic        h_eol;
  logic [31:0] h_x;
  logic [31:0] h_y;

  // Monitor: score every accepted beat, stall hold and frame_done at the negedge.
  always @(negedge clk) begin
    int pos;
    int x;
    int y;
    if (!rst_n) begin
      beats    = 0;
      frames   = 0;
      acc_last = 1'b0;
      held     = 1'b0;
      check("rst_valid", 32'(m_valid), 32'd0);
    end else begin
      check("frame_done", 32'(frame_done), 32'(acc_last));
`ifdef LOGO_FRAME_COUNT_EN
      check("frame_count", 32'(frame_count), 32'(frames % 65536));
`endif
      if (held) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(h_data));
        check("hold_sof", 32'(m_sof), 32'(h_sof));
        check("hold_eol", 32'(m_eol), 32'(h_eol));
        check("hold_x", pix_x, h_x);
        check("hold_y", pix_y, h_y);
      end
      held   = m_valid && !m_ready;
      h_data = m_data;
      h_sof  = m_sof;
      h_eol  = m_eol;
      h_x    = pix_x;
      h_y    = pix_y;
      if (m_valid && m_ready) begin
        pos = beats % N;
        x   = pos % W;
        y   = pos / W;
        check("beat_data", 32'(m_data), 32'((x + y) % 4 + 1));
        check("beat_sof", 32'(m_sof), 32'(pos == 0));
        check("beat_eol", 32'(m_eol), 32'(x == W - 1));
        acc_last = (pos == N - 1);
        if (acc_last) frames++;
        beats++;
      end else begin
        acc_last = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_sof"}, 32'(m_sof), 32'd0);
    check({tag, "_eol"}, 32'(m_eol), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check({tag, "_x"}, pix_x, 32'd0);
    check({tag, "_y"}, pix_y, 32'd0);
  endtask

  initial begin
    int cyc;
    int base;
    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
`ifdef LOGO_FRAME_COUNT_EN
    check("reset_fcount", 32'(frame_count), 32'd0);
`endif

    // Released with enable low: nothing moves.
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle_outputs("idle");
      tick();
    end

    // First beat arrives on the second edge after enable; then full rate.
    m_ready = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    check("lat0_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat1_busy", 32'(busy), 32'd1);
    check("lat1_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(m_valid), 32'd1);
    check("first_sof", 32'(m_sof), 32'd1);
    check("first_data", 32'(m_data), 32'd1);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      check("fullrate_valid", 32'(m_valid), 32'd1);
    end

    // Random backpressure with continuous enable.
    for (int i = 0; i < 200; i++) begin
      tick();
      m_ready = 1'($urandom_range(0, 3) != 0);
    end

    // Drop enable mid-stream: frame must finish, then go quiet.
    tick();
    enable = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("drop_busy_timeout", 32'(busy), 32'd0);
    m_ready = 1'b1;
    cyc = 0;
    while (m_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("drain_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    #1;
    check("drop_frame_boundary", 32'(beats % N), 32'd0);
    base = beats;
    repeat (10) tick();
    check("quiet_valid", 32'(m_valid), 32'd0);
    check("quiet_beats", 32'(beats), 32'(base));

    // Asynchronous reset in the middle of a frame.
    enable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      m_ready = 1'($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    tick();
    tick();
    rst_n   = 1'b0;
    m_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    cyc = 0;
    while (beats < 2 * N && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("restart_beats", 32'(beats >= 2 * N), 32'd1);
    @(negedge clk);
    #1;
    check("restart_frames", 32'(frames), 32'd2);
`ifdef LOGO_FRAME_COUNT_EN
    check("restart_fcount", 32'(frame_count), 32'd2);
`endif
    for (int i = 0; i < 60; i++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
